// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/load-unit producers, the issue stage, and the
// register-file write port with its hazard-check read addresses.
interface regfile_wb_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic        hazard_a;
  logic        hazard_b;
  logic [4:0]  RW;
  logic [31:0] Bus_W;
  logic        reg_write;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd, RA, RB,
    input  alu_ready, mem_ready, hazard_a, hazard_b,
    input  RW, Bus_W, reg_write
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd, RA, RB,
    output alu_ready, mem_ready, hazard_a, hazard_b,
    output RW, Bus_W, reg_write
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load-unit writebacks onto a single registered register-file
// write port, with starvation protection for the ALU and a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam logic [0:0] MEM_PRI = 1'b0;
  localparam logic [0:0] ALU_PRI = 1'b1;

  logic [0:0]  state;
  logic [3:0]  starve_cnt;
  logic [3:0]  starve_next;
  logic        grant_alu;
  logic        grant_mem;
  logic        alu_xfer;
  logic        mem_xfer;
  logic [31:0] pending;
  logic [31:0] pending_set;
  logic [31:0] pending_clr;

  // Grants are gated by rst so no handshake can complete while reset is held.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!rst) begin
      if (state == MEM_PRI) begin
        grant_mem = bus.mem_valid;
        grant_alu = bus.alu_valid && !bus.mem_valid;
      end else begin
        grant_alu = bus.alu_valid;
        grant_mem = bus.mem_valid && !bus.alu_valid;
      end
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;
  assign alu_xfer      = bus.alu_valid && grant_alu;
  assign mem_xfer      = bus.mem_valid && grant_mem;

  always_comb begin
    starve_next = '0;
    if (bus.alu_valid && !grant_alu)
      starve_next = (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MEM_PRI;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_next;
      case (state)
        MEM_PRI: if (starve_next == 4'(STARVE_LIMIT)) state <= ALU_PRI;
        default: if (alu_xfer) state <= MEM_PRI;
      endcase
    end
  end

  // Writes to x0 complete the handshake but never reach the write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.reg_write <= 1'b0;
      bus.RW        <= '0;
      bus.Bus_W     <= '0;
    end else begin
      bus.reg_write <= 1'b0;
      if (alu_xfer && bus.alu_rd != '0) begin
        bus.reg_write <= 1'b1;
        bus.RW        <= bus.alu_rd;
        bus.Bus_W     <= bus.alu_data;
      end else if (mem_xfer && bus.mem_rd != '0) begin
        bus.reg_write <= 1'b1;
        bus.RW        <= bus.mem_rd;
        bus.Bus_W     <= bus.mem_data;
      end
    end
  end

  always_comb begin
    pending_set = '0;
    pending_clr = '0;
    if (bus.issue_valid && bus.issue_rd != '0)
      pending_set = 32'd1 << bus.issue_rd;
    if (bus.reg_write)
      pending_clr = 32'd1 << bus.RW;
  end

  // Set is applied after clear so a same-edge reissue keeps the bit pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pending <= '0;
    else
      pending <= ((pending & ~pending_clr) | pending_set) & ~32'd1;
  end

  assign bus.hazard_a = pending[bus.RA] && (bus.RA != '0);
  assign bus.hazard_b = pending[bus.RB] && (bus.RB != '0);

endmodule
